// File: rtl/rx_frame_ctrl_pkg.sv
// Shared definitions for the receive frame sequencer: state encoding,
// field lengths and SIGNAL field bit positions.
package rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SIGNAL,
    ST_SERVICE,
    ST_DATA,
    ST_FLUSH,
    ST_ERROR
  } state_t;

  localparam int SIG_BITS     = 24;
  localparam int SVC_BITS     = 16;
  localparam int HDR_OUT_BITS = SIG_BITS + SVC_BITS;

  localparam int RATE_LSB = 0;
  localparam int RATE_W   = 4;
  localparam int RES_POS  = 4;
  localparam int LEN_LSB  = 5;
  localparam int LEN_W    = 12;
  localparam int PAR_POS  = 17;

  // Even parity: XOR over RATE..PAR must come out zero.
  function automatic logic sig_parity_ok(input logic [SIG_BITS-1:0] sig);
    return ~^sig[PAR_POS:0];
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_byte_packer.sv
// Packs descrambled DATA bits into bytes, skipping the SIGNAL+SERVICE
// header bits that the descrambler also emits.
module rx_byte_packer
  import rx_frame_ctrl_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             bit_i,
  input  logic             bit_vld_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [7:0]       byte_o,
  output logic             byte_vld_o,
  output logic             byte_last_o
);

  logic [5:0]       out_cnt_q, out_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]       sr_q, sr_d;
  logic [7:0]       byte_q, byte_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;

  always_comb begin
    out_cnt_d  = out_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    byte_d     = byte_q;
    vld_d      = 1'b0;
    last_d     = 1'b0;
    if (clr) begin
      out_cnt_d  = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sr_d       = '0;
    end else if (bit_vld_i) begin
      if (out_cnt_q < 6'(HDR_OUT_BITS)) begin
        out_cnt_d = out_cnt_q + 6'd1;
      end else begin
        // LSB-first: the newest bit enters at the top and walks down.
        sr_d      = {bit_i, sr_q[6:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_d     = {bit_i, sr_q};
          vld_d      = 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
          last_d     = (byte_cnt_d == len_i);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      byte_q     <= byte_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
    end
  end

  assign byte_o      = byte_q;
  assign byte_vld_o  = vld_q;
  assign byte_last_o = last_q;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: arms the descrambler, gates bits into it,
// decodes/checks SIGNAL, counts SERVICE/DATA and delivers packed bytes.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int MAX_LEN    = 4095,
  parameter int ARM_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_in_valid,
  output logic             ds_reset_n,
  output logic             ds_data_in,
  output logic             ds_data_in_valid,
  input  logic             ds_data_out,
  input  logic             ds_data_out_valid,
  output logic [RATE_W-1:0] sig_rate,
  output logic [LEN_W-1:0]  sig_length,
  output logic             sig_valid,
  output logic             sig_err,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             byte_last,
  output logic             frame_done,
  output logic             busy
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  state_t              state_q, state_d;
  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic [14:0]         in_cnt_q, in_cnt_d;
  logic [SIG_BITS-1:0] sig_sr_q, sig_sr_d;
  logic                chk_pend_q, chk_pend_d;
  logic [RATE_W-1:0]   sig_rate_q, sig_rate_d;
  logic [LEN_W-1:0]    sig_length_q, sig_length_d;
  logic [14:0]         data_bits;
  logic                sig_ok;
  logic                acc;
  logic                pk_valid, pk_last;

  assign ds_reset_n       = (state_q == ST_SIGNAL) || (state_q == ST_SERVICE) ||
                            (state_q == ST_DATA)   || (state_q == ST_FLUSH);
  assign busy             = (state_q != ST_IDLE);
  assign ds_data_in       = bit_in;
  assign ds_data_in_valid = bit_in_valid && ((state_q == ST_SIGNAL) ||
                            (state_q == ST_SERVICE) || (state_q == ST_DATA));
  assign acc              = ds_data_in_valid;
  assign data_bits        = 15'(sig_length_q) << 3;
  assign sig_ok           = sig_parity_ok(sig_sr_q) && !sig_sr_q[RES_POS] &&
                            (sig_length_q != '0) && (sig_length_q <= LEN_W'(MAX_LEN));

  always_comb begin
    state_d      = state_q;
    arm_cnt_d    = arm_cnt_q;
    in_cnt_d     = in_cnt_q;
    sig_sr_d     = sig_sr_q;
    chk_pend_d   = 1'b0;
    sig_rate_d   = sig_rate_q;
    sig_length_d = sig_length_q;
    sig_valid    = 1'b0;
    sig_err      = 1'b0;
    frame_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        arm_cnt_d = '0;
        in_cnt_d  = '0;
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
          state_d  = ST_SIGNAL;
          in_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      ST_SIGNAL: begin
        if (chk_pend_q) begin
          // A bit arriving during the check cycle already belongs to SERVICE.
          if (acc) in_cnt_d = in_cnt_q + 15'd1;
          if (sig_ok) begin
            sig_valid = 1'b1;
            state_d   = ST_SERVICE;
          end else begin
            sig_err = 1'b1;
            state_d = ST_ERROR;
          end
        end else if (acc) begin
          sig_sr_d = {bit_in, sig_sr_q[SIG_BITS-1:1]};
          if (in_cnt_q == 15'(SIG_BITS - 1)) begin
            in_cnt_d     = '0;
            chk_pend_d   = 1'b1;
            sig_rate_d   = sig_sr_d[RATE_LSB +: RATE_W];
            sig_length_d = sig_sr_d[LEN_LSB +: LEN_W];
          end else begin
            in_cnt_d = in_cnt_q + 15'd1;
          end
        end
      end
      ST_SERVICE: begin
        if (acc) begin
          if (in_cnt_q == 15'(SVC_BITS - 1)) begin
            in_cnt_d = '0;
            state_d  = ST_DATA;
          end else begin
            in_cnt_d = in_cnt_q + 15'd1;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          if (in_cnt_q == data_bits - 15'd1) begin
            in_cnt_d = '0;
            state_d  = ST_FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + 15'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (pk_valid && pk_last) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      arm_cnt_q    <= '0;
      in_cnt_q     <= '0;
      sig_sr_q     <= '0;
      chk_pend_q   <= 1'b0;
      sig_rate_q   <= '0;
      sig_length_q <= '0;
    end else begin
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      in_cnt_q     <= in_cnt_d;
      sig_sr_q     <= sig_sr_d;
      chk_pend_q   <= chk_pend_d;
      sig_rate_q   <= sig_rate_d;
      sig_length_q <= sig_length_d;
    end
  end

  rx_byte_packer u_packer (
    .Clk         (Clk),
    .Reset       (Reset),
    .clr         (!ds_reset_n),
    .bit_i       (ds_data_out),
    .bit_vld_i   (ds_data_out_valid),
    .len_i       (sig_length_q),
    .byte_o      (byte_out),
    .byte_vld_o  (pk_valid),
    .byte_last_o (pk_last)
  );

  assign byte_valid = pk_valid;
  assign byte_last  = pk_last;
  assign sig_rate   = sig_rate_q;
  assign sig_length = sig_length_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a self-synchronising descrambler stub.
module tb_rx_frame_ctrl;

  localparam int MAXL = 100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_in_valid = 1'b0;
  logic        ds_reset_n, ds_data_in, ds_data_in_valid;
  logic        ds_data_out = 1'b0;
  logic        ds_data_out_valid = 1'b0;
  logic [3:0]  sig_rate;
  logic [11:0] sig_length;
  logic        sig_valid, sig_err, byte_valid, byte_last, frame_done, busy;
  logic [7:0]  byte_out;

  always #5 Clk = ~Clk;

  rx_frame_ctrl #(.MAX_LEN(MAXL), .ARM_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .bit_in(bit_in), .bit_in_valid(bit_in_valid),
    .ds_reset_n(ds_reset_n), .ds_data_in(ds_data_in), .ds_data_in_valid(ds_data_in_valid),
    .ds_data_out(ds_data_out), .ds_data_out_valid(ds_data_out_valid),
    .sig_rate(sig_rate), .sig_length(sig_length), .sig_valid(sig_valid), .sig_err(sig_err),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
    .frame_done(frame_done), .busy(busy)
  );

  // Descrambler stub: x^7+x^4+1 self-synchronising, one cycle of latency.
  logic [6:0] ds_s = '0;
  always @(posedge Clk) begin
    if (!ds_reset_n) begin
      ds_s <= '0;
      ds_data_out_valid <= 1'b0;
    end else if (ds_data_in_valid) begin
      ds_data_out <= ds_data_in ^ ds_s[6] ^ ds_s[3];
      ds_s <= {ds_s[5:0], ds_data_in};
      ds_data_out_valid <= 1'b1;
    end else begin
      ds_data_out_valid <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  logic       fb [0:1023];
  logic [7:0] pl [0:127];
  logic [7:0] rxq [$];
  int last_idx, fd_cnt, sv_cnt, se_cnt, coin_bad;
  logic       obs_sv, obs_se;
  logic [3:0] obs_rate;
  logic [11:0] obs_len;

  always @(negedge Clk) begin
    if (Reset) begin
      if (byte_valid) begin
        rxq.push_back(byte_out);
        if (byte_last) last_idx = rxq.size() - 1;
      end
      if (frame_done) begin
        fd_cnt++;
        if (!(byte_valid && byte_last)) coin_bad++;
      end
      if (sig_valid) sv_cnt++;
      if (sig_err) se_cnt++;
    end
  end

  task automatic clear_mon();
    rxq.delete();
    last_idx = -1; fd_cnt = 0; sv_cnt = 0; se_cnt = 0; coin_bad = 0;
    obs_sv = 1'b0; obs_se = 1'b0; obs_rate = '0; obs_len = '0;
  endtask

  // SIGNAL goes out raw; SERVICE and DATA are scrambled so that the stub recovers them.
  task automatic build_frame(input logic [3:0] rate, input logic [11:0] len, input logic res,
                             input logic pflip, input logic [15:0] svc);
    logic [23:0] sig;
    logic [6:0]  s;
    logic [7:0]  tmp;
    logic        t;
    int n;
    sig = '0;
    sig[3:0] = rate; sig[4] = res; sig[16:5] = len;
    sig[17] = (^{len, res, rate}) ^ pflip;
    s = '0; n = 0;
    for (int i = 0; i < 24; i++) begin fb[n] = sig[i]; s = {s[5:0], sig[i]}; n++; end
    for (int i = 0; i < 16; i++) begin
      t = svc[i] ^ s[6] ^ s[3]; fb[n] = t; s = {s[5:0], t}; n++;
    end
    for (int i = 0; i < int'(len) * 8; i++) begin
      tmp = pl[i / 8];
      t = tmp[i % 8] ^ s[6] ^ s[3]; fb[n] = t; s = {s[5:0], t}; n++;
    end
  endtask

  task automatic start_frame(output int lowcnt);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (ds_reset_n) break;
      lowcnt++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic send_bits(input int nsend, input int start_at, input bit gaps);
    for (int i = 0; i < nsend; i++) begin
      if (gaps) begin
        for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) begin
          bit_in_valid = 1'b0; bit_in = 1'($urandom_range(1, 0));
          @(posedge Clk); #1;
        end
      end
      bit_in = fb[i]; bit_in_valid = 1'b1; start = (i == start_at);
      @(posedge Clk); #1;
      if (i == 23) begin
        obs_sv = sig_valid; obs_se = sig_err; obs_rate = sig_rate; obs_len = sig_length;
      end
    end
    bit_in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({ds_reset_n, busy, sig_valid, sig_err, byte_valid, byte_last, frame_done} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {ds_reset_n, busy, sig_valid, sig_err, byte_valid, byte_last, frame_done});
    end
    checks++;
    if ({sig_rate, sig_length, byte_out} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 000000", {sig_rate, sig_length, byte_out});
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    int low; bit ok;
    clear_mon();
    pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'h7E;
    build_frame(4'b1101, 12'd3, 1'b0, 1'b0, 16'h0000);
    start_frame(low);
    checks++; if (low !== 2) begin errors++; $display("FAIL basic_arm: got %0d expected 2", low); end
    send_bits(64, -1, 1'b0);
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done: got %0d expected 1", ok); end
    checks++; if ({obs_sv, obs_se} !== 2'b10) begin errors++; $display("FAIL basic_sigvalid: got %b expected 10", {obs_sv, obs_se}); end
    checks++; if (obs_rate !== 4'hD) begin errors++; $display("FAIL basic_rate: got %h expected d", obs_rate); end
    checks++; if (obs_len !== 12'd3) begin errors++; $display("FAIL basic_len: got %0d expected 3", obs_len); end
    checks++; if (rxq.size() !== 3) begin errors++; $display("FAIL basic_nbytes: got %0d expected 3", rxq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== pl[i]) begin
        errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, pl[i]);
      end
    end
    checks++; if (last_idx !== 2) begin errors++; $display("FAIL basic_last_idx: got %0d expected 2", last_idx); end
    checks++; if ({fd_cnt, coin_bad} !== {32'd1, 32'd0}) begin errors++; $display("FAIL basic_done_coincide: got %0d/%0d expected 1/0", fd_cnt, coin_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_parity_err();
    int low;
    clear_mon();
    build_frame(4'h5, 12'd10, 1'b0, 1'b1, 16'h0000);
    start_frame(low);
    send_bits(24, -1, 1'b0);
    checks++; if ({obs_sv, obs_se} !== 2'b01) begin errors++; $display("FAIL par_sigerr: got %b expected 01", {obs_sv, obs_se}); end
    @(posedge Clk); #1;
    checks++; if ({ds_reset_n, busy} !== 2'b01) begin errors++; $display("FAIL par_error_state: got %b expected 01", {ds_reset_n, busy}); end
    @(posedge Clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_busy_fall: got %b expected 0", busy); end
    repeat (5) @(posedge Clk);
    #1;
    checks++; if ({rxq.size(), fd_cnt, sv_cnt} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL par_no_output: got %0d/%0d/%0d expected 0/0/0", rxq.size(), fd_cnt, sv_cnt);
    end
  endtask

  task automatic test_len_bounds();
    int low; bit ok; int bad;
    logic [11:0] lens [0:2];
    logic        ress [0:2];
    lens[0] = 12'd0; lens[1] = 12'(MAXL + 1); lens[2] = 12'd5;
    ress[0] = 1'b0;  ress[1] = 1'b0;          ress[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      clear_mon();
      build_frame(4'hB, lens[j], ress[j], 1'b0, 16'h0000);
      start_frame(low);
      send_bits(24, -1, 1'b0);
      checks++; if ({obs_sv, obs_se} !== 2'b01) begin errors++; $display("FAIL len_reject%0d: got %b expected 01", j, {obs_sv, obs_se}); end
      repeat (3) @(posedge Clk);
      #1;
    end
    clear_mon();
    for (int i = 0; i < MAXL; i++) pl[i] = 8'(i * 7 + 3);
    build_frame(4'h8, 12'(MAXL), 1'b0, 1'b0, 16'h0000);
    start_frame(low);
    send_bits(40 + MAXL * 8, -1, 1'b0);
    wait_done(ok);
    checks++; if ({obs_sv, ok} !== 2'b11) begin errors++; $display("FAIL len_max_done: got %b expected 11", {obs_sv, ok}); end
    checks++; if (rxq.size() !== MAXL) begin errors++; $display("FAIL len_max_nbytes: got %0d expected %0d", rxq.size(), MAXL); end
    bad = 0;
    for (int i = 0; i < MAXL && i < rxq.size(); i++) if (rxq[i] !== pl[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL len_max_bytes: got %0d wrong bytes expected 0", bad); end
    checks++; if (last_idx !== MAXL - 1) begin errors++; $display("FAIL len_max_last: got %0d expected %0d", last_idx, MAXL - 1); end
  endtask

  task automatic test_gaps();
    int low; bit ok;
    clear_mon();
    pl[0] = 8'hC3; pl[1] = 8'h19;
    build_frame(4'h3, 12'd2, 1'b0, 1'b0, 16'h005D);
    start_frame(low);
    send_bits(56, -1, 1'b1);
    wait_done(ok);
    checks++; if ({ok, rxq.size()} !== {1'b1, 32'd2}) begin errors++; $display("FAIL gaps_count: got done=%0d bytes=%0d expected 1/2", ok, rxq.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== pl[i]) begin
        errors++; $display("FAIL gaps_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, pl[i]);
      end
    end
  endtask

  task automatic test_start_ignored_and_abort();
    int low; bit ok;
    clear_mon();
    pl[0] = 8'h11; pl[1] = 8'hE7;
    build_frame(4'h9, 12'd2, 1'b0, 1'b0, 16'hA5A5);
    start_frame(low);
    send_bits(56, 43, 1'b0);
    wait_done(ok);
    checks++; if ({ok, rxq.size()} !== {1'b1, 32'd2}) begin errors++; $display("FAIL start_ign_count: got done=%0d bytes=%0d expected 1/2", ok, rxq.size()); end
    checks++; if (rxq.size() < 2 || rxq[1] !== 8'hE7) begin errors++; $display("FAIL start_ign_byte: got %h expected e7", (rxq.size() > 1) ? rxq[1] : 8'hxx); end
    repeat (3) @(posedge Clk);
    #1;
    checks++; if ({busy, ds_reset_n} !== 2'b00) begin errors++; $display("FAIL start_ign_idle: got %b expected 00", {busy, ds_reset_n}); end
    clear_mon();
    pl[0] = 8'h5A; pl[1] = 8'hF0; pl[2] = 8'h0F;
    build_frame(4'hD, 12'd3, 1'b0, 1'b0, 16'h0000);
    start_frame(low);
    send_bits(45, -1, 1'b0);
    bit_in = fb[45]; bit_in_valid = 1'b1;
    Reset = 1'b0;
    #1;
    checks++;
    if ({ds_reset_n, busy, sig_valid, sig_err, byte_valid, byte_last, frame_done, ds_data_in_valid} !== 8'b0) begin
      errors++; $display("FAIL abort_ctrl: got %b expected 00000000",
        {ds_reset_n, busy, sig_valid, sig_err, byte_valid, byte_last, frame_done, ds_data_in_valid});
    end
    checks++; if ({sig_rate, sig_length, byte_out} !== 24'h0) begin errors++; $display("FAIL abort_data: got %h expected 000000", {sig_rate, sig_length, byte_out}); end
    bit_in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    checks++; if ({fd_cnt, rxq.size()} !== {32'd0, 32'd0}) begin errors++; $display("FAIL abort_no_done: got %0d/%0d expected 0/0", fd_cnt, rxq.size()); end
  endtask

  task automatic test_back_to_back();
    int low; bit ok;
    clear_mon();
    pl[0] = 8'h81;
    build_frame(4'h1, 12'd1, 1'b0, 1'b0, 16'h1234);
    start_frame(low);
    send_bits(48, -1, 1'b0);
    wait_done(ok);
    checks++; if ({ok, rxq.size()} !== {1'b1, 32'd1} || rxq[0] !== 8'h81) begin
      errors++; $display("FAIL b2b_first: got done=%0d bytes=%0d expected 1/1 with 81", ok, rxq.size());
    end
    clear_mon();
    pl[0] = 8'h6E; pl[1] = 8'hB2;
    build_frame(4'hF, 12'd2, 1'b0, 1'b0, 16'h0F0F);
    start_frame(low);
    checks++; if (low !== 2) begin errors++; $display("FAIL b2b_arm: got %0d expected 2", low); end
    send_bits(56, -1, 1'b0);
    wait_done(ok);
    checks++; if ({obs_rate, obs_len} !== {4'hF, 12'd2}) begin errors++; $display("FAIL b2b_signal: got %h expected f002", {obs_rate, obs_len}); end
    checks++; if ({ok, rxq.size()} !== {1'b1, 32'd2}) begin errors++; $display("FAIL b2b_count: got done=%0d bytes=%0d expected 1/2", ok, rxq.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== pl[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, pl[i]);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_parity_err();
    test_len_bounds();
    test_gaps();
    test_start_ignored_and_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Receive-side frame sequencer that owns the bit descrambler instance (deScrambler) for one frame at a time. It re-arms the descrambler through its active-low reset, gates the serial bit stream into it, and decodes and checks the SIGNAL field. It counts SERVICE and DATA bits, packs the descrambled DATA bits into bytes, and returns the descrambler to reset after each frame or error. It sits between the demapper/deinterleaver bit output and the MAC-side byte interface.

Parameters:
MAX_LEN, 4095, largest legal SIGNAL LENGTH in bytes (1..4095)
ARM_CYCLES, 2, cycles ds_reset_n is held low before a frame is accepted (>=1)

Ports:
Clk  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-low reset
start  in  1  frame-start pulse; honoured only in IDLE
bit_in  in  1  serial received bit
bit_in_valid  in  1  bit_in qualifier
ds_reset_n  out  1  drives descrambler Reset (active-low)
ds_data_in  out  1  = bit_in (combinational)
ds_data_in_valid  out  1  bit_in_valid gated by state (combinational)
ds_data_out  in  1  descrambler output bit
ds_data_out_valid  in  1  descrambler output qualifier
sig_rate  out  4  decoded RATE
sig_length  out  12  decoded LENGTH in bytes
sig_valid  out  1  one-cycle pulse, SIGNAL passed all checks
sig_err  out  1  one-cycle pulse, SIGNAL failed a check
byte_out  out  8  packed descrambled byte
byte_valid  out  1  one-cycle pulse per byte
byte_last  out  1  qualifies final byte_valid of the frame
frame_done  out  1  one-cycle pulse, frame fully delivered
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: ds_reset_n=0, all pulses=0, sig_rate=0, sig_length=0, byte_out=0, busy=0, state=IDLE. Asserting Reset mid-frame aborts immediately with no frame_done.
- States: IDLE, ARM, SIGNAL, SERVICE, DATA, FLUSH, ERROR.
- IDLE: ds_reset_n=0. When start=1, go to ARM. Input bits are dropped.
- ARM: ds_reset_n=0 for ARM_CYCLES cycles, then ds_reset_n=1 and go to SIGNAL. Bits arriving during ARM are dropped.
- ds_data_in_valid = bit_in_valid only in SIGNAL, SERVICE or DATA; otherwise 0.
- in_cnt (15b) counts accepted input bits from 0 within each field.
- SIGNAL field, 24 bits, received LSB-first:
  - bits 0-3: RATE
  - bit 4: reserved
  - bits 5-16: LENGTH
  - bit 17: even parity over bits 0-17
  - bits 18-23: tail
- After bit 23 is accepted, the block registers sig_rate and sig_length and runs the checks in the next cycle:
  - parity even, reserved=0, 1<=LENGTH<=MAX_LEN -> sig_valid pulse, go to SERVICE.
  - any check fails -> sig_err pulse, go to ERROR.
- SERVICE: 16 bits, then DATA.
- DATA: LENGTH*8 bits (width-extend to 15b before the shift). After the last bit is accepted, go to FLUSH.
- start is ignored whenever busy=1.
- Output packing:
  - out_cnt counts ds_data_out_valid pulses after ARM.
  - The first 40 (SIGNAL + SERVICE) are discarded.
  - Subsequent bits are shifted LSB-first into a byte register.
  - Every 8th bit: byte_valid=1 on the next cycle. byte_last=1 when the byte count equals sig_length.
- FLUSH: waits for the final byte (the descrambler adds 1 cycle of latency). frame_done pulses in the same cycle as byte_last, then the block goes to IDLE. ds_reset_n drops in that next cycle.
- ERROR: ds_reset_n=0 immediately, no bytes are emitted. The block returns to IDLE after 1 cycle.
- Bits stalled (bit_in_valid=0) hold all counters. Gaps of any length are legal.
- Counters never wrap: maximum is 4095*8 = 32760 < 2^15.

Decomposition:
- Shared package holds:
  - State encoding.
  - Field-length constants SIG_BITS=24, SVC_BITS=16, HDR_OUT_BITS=40.
  - Field bit positions: RATE [0:3], RES 4, LEN [5:16], PAR 17.
- One sub-module: rx_byte_packer (bit counter, skip count, shift register, byte_valid/byte_last generation).

Test Plan:
- RATE=4'b1101, LENGTH=3, correct parity, 40+24 bits -> sig_valid one cycle after bit 23; 3 byte_valid pulses; byte_last and frame_done coincide on the 3rd byte.
- Parity bit flipped in SIGNAL -> sig_err pulse, ds_reset_n=0 next cycle, no byte_valid, busy falls 2 cycles later.
- LENGTH=0, then LENGTH=MAX_LEN+1 with MAX_LEN=100 -> sig_err both times; LENGTH=100 -> 100 bytes and frame_done.
- Random bit_in_valid gaps (50% duty), LENGTH=2, known SERVICE seed -> bytes match the software descrambler model; no extra or missing bytes.
- start re-asserted mid-DATA -> ignored; Reset asserted at DATA bit 5 -> all outputs at reset values within the same cycle (asynchronous), no frame_done.
- Back-to-back frames: start one cycle after frame_done -> ARM holds ds_reset_n low for 2 cycles; the second frame decodes correctly.
